// File: rtl/plab5_mcore_mem_req_cmsg_pack_queue.sv
// N-channel memory-request control-message packer: round-robin arbiter feeding an output FIFO.
// Optional opaque tagging with the source channel is enabled by PLAB5_MCORE_MEM_REQ_CMSG_OPQ_TAG_EN.
module plab5_mcore_mem_req_cmsg_pack_queue #(
    parameter int p_num_ports    = 2,
    parameter int p_opaque_nbits = 8,
    parameter int p_addr_nbits   = 32,
    parameter int p_data_nbits   = 32,
    parameter int p_num_entries  = 4,
    localparam int c_len_nbits   = $clog2(p_data_nbits / 8),
    localparam int c_msg_nbits   = 3 + p_opaque_nbits + p_addr_nbits + c_len_nbits,
    localparam int c_port_nbits  = (p_num_ports > 1) ? $clog2(p_num_ports) : 1,
    localparam int c_count_nbits = $clog2(p_num_entries) + 1
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [p_num_ports-1:0]                 in_val,
    output logic [p_num_ports-1:0]                 in_rdy,
    input  logic [p_num_ports-1:0]                 in_domain,
    input  logic [p_num_ports*3-1:0]               in_type,
    input  logic [p_num_ports*p_opaque_nbits-1:0]  in_opaque,
    input  logic [p_num_ports*p_addr_nbits-1:0]    in_addr,
    input  logic [p_num_ports*c_len_nbits-1:0]     in_len,
    output logic                                   out_val,
    input  logic                                   out_rdy,
    output logic [c_msg_nbits-1:0]                 out_msg,
    output logic                                   out_domain,
    output logic [c_port_nbits-1:0]                out_port,
    output logic [c_count_nbits-1:0]               count
);

    localparam int c_ptr_nbits = $clog2(p_num_entries);
    localparam int c_tag_nbits = $clog2(p_num_ports);

    logic [c_port_nbits-1:0]   prio;
    logic [c_port_nbits-1:0]   grant;
    int                        grant_idx;
    int                        scan_idx;
    logic                      found;
    logic                      any_val;
    logic                      full;
    logic                      enq;
    logic                      deq;
    logic [p_opaque_nbits-1:0] sel_opaque;
    logic [c_msg_nbits-1:0]    packed_msg;

    logic [c_ptr_nbits-1:0]    head;
    logic [c_ptr_nbits-1:0]    tail;

    logic [c_msg_nbits-1:0]    msg_mem  [p_num_entries];
    logic                      dom_mem  [p_num_entries];
    logic [c_port_nbits-1:0]   port_mem [p_num_entries];

    // First valid channel at or after the priority pointer, wrapping around.
    always_comb begin
        grant_idx = 0;
        scan_idx  = 0;
        found     = 1'b0;
        for (int k = 0; k < p_num_ports; k++) begin
            scan_idx = int'(prio) + k;
            if (scan_idx >= p_num_ports) begin
                scan_idx = scan_idx - p_num_ports;
            end
            if (!found && in_val[scan_idx]) begin
                found     = 1'b1;
                grant_idx = scan_idx;
            end
        end
        grant = c_port_nbits'(grant_idx);
    end

    assign any_val = |in_val;
    assign full    = (count == c_count_nbits'(p_num_entries));
    assign enq     = reset && any_val && !full;
    assign deq     = out_val && out_rdy;

    always_comb begin
        in_rdy            = '0;
        in_rdy[grant_idx] = enq;
    end

    always_comb begin
        sel_opaque = in_opaque[grant_idx*p_opaque_nbits +: p_opaque_nbits];
`ifdef PLAB5_MCORE_MEM_REQ_CMSG_OPQ_TAG_EN
        for (int b = 0; b < c_tag_nbits; b++) begin
            sel_opaque[b] = grant[b];
        end
`endif
        packed_msg = {in_type[grant_idx*3 +: 3],
                      sel_opaque,
                      in_addr[grant_idx*p_addr_nbits +: p_addr_nbits],
                      in_len[grant_idx*c_len_nbits +: c_len_nbits]};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            prio  <= '0;
        end else begin
            if (enq) begin
                tail <= tail + 1'b1;
                if (grant == c_port_nbits'(p_num_ports - 1)) begin
                    prio <= '0;
                end else begin
                    prio <= grant + 1'b1;
                end
            end
            if (deq) begin
                head <= head + 1'b1;
            end
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: nothing is visible unless count says the slot is live.
    always_ff @(posedge clk) begin
        if (enq) begin
            msg_mem[tail]  <= packed_msg;
            dom_mem[tail]  <= in_domain[grant_idx];
            port_mem[tail] <= grant;
        end
    end

    assign out_val    = (count != '0);
    assign out_msg    = out_val ? msg_mem[head]  : '0;
    assign out_domain = out_val ? dom_mem[head]  : 1'b0;
    assign out_port   = out_val ? port_mem[head] : '0;

endmodule

// File: doc/plab5_mcore_mem_req_cmsg_pack_queue.md
Name: plab5_mcore_mem_req_cmsg_pack_queue

Overview:
- N-channel memory-request control-message packer with arbitration and an output FIFO.
- Each requester presents type/opaque/addr/len plus a security domain bit over val/rdy.
- One request per cycle is round-robin selected, packed as {type, opaque, addr, len} and queued with its domain bit.
- Sits between core-side request ports and the shared memory-request network/cache in the mcore system.

Parameters:
- p_num_ports, 2, number of requester channels N (1..8)
- p_opaque_nbits, 8, opaque field width o
- p_addr_nbits, 32, address field width a
- p_data_nbits, 32, data width d; len width l = clog2(d/8) (2 for d=32)
- p_num_entries, 4, output FIFO depth (power of 2, >=2)
- Derived: c = 3+o+a+l (45 at defaults); t = 3 (type width)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- in_val  in  N  per-channel request valid
- in_rdy  out  N  per-channel request ready
- in_domain  in  N  per-channel domain (0=L, 1=H)
- in_type  in  N*3  per-channel type; channel i at [i*3+:3]
- in_opaque  in  N*o  per-channel opaque
- in_addr  in  N*a  per-channel address
- in_len  in  N*l  per-channel length
- out_val  out  1  head entry valid
- out_rdy  in  1  downstream ready
- out_msg  out  c  packed control message: [c-1:c-3]=type, [l+a+o-1:l+a]=opaque, [l+a-1:l]=addr, [l-1:0]=len
- out_domain  out  1  domain bit of head entry
- out_port  out  clog2(N) (min 1)  source channel of head entry
- count  out  clog2(p_num_entries)+1  current occupancy

Behaviour:
- Reset (reset==0 at posedge): FIFO empty, count=0, out_val=0, out_msg=0, out_domain=0, out_port=0, priority pointer=0, in_rdy=0 while reset is low.
- Arbitration: combinational round-robin over in_val, starting at the priority pointer. Grant g is the first valid channel at or after the pointer, with wrap-around.
- in_rdy[i] = (i==g) & any(in_val) & (count<p_num_entries). At most one bit is set. in_rdy never depends on out_rdy.
- Enqueue fires when in_val[g] & in_rdy[g]. The entry {packed msg, in_domain[g], g} is written at the tail. The pointer moves to (g+1) mod N on the same edge; otherwise the pointer holds.
- Dequeue fires when out_val & out_rdy; the head advances.
- Latency: an accepted request appears on out_msg/out_val the next cycle. There is no combinational in->out bypass.
- out_val = (count!=0). out_msg, out_domain and out_port come from the head entry and are held stable while out_val & !out_rdy.
- Simultaneous enq+deq: count is unchanged and both pointers advance. When full, no enqueue occurs, even with out_rdy high (deq only, count-1).
- When empty, out_rdy is ignored and count stays 0.
- Head/tail pointers wrap modulo p_num_entries.
- Packing is pure bit concatenation. No field is truncated or extended; widths match the parameters exactly.
- Reset mid-operation: all queued entries are discarded and the pointer returns to 0. No partial output is emitted.

Optional Feature:
- Macro PLAB5_MCORE_MEM_REQ_CMSG_OPQ_TAG_EN.
- Defined: the low clog2(N) bits of the opaque field in the queued msg are replaced with the source channel index g; the upper opaque bits pass through. This lets responses be routed back by opaque.
- Undefined: opaque is passed through unmodified. out_port is provided in both cases.

Test Plan:
- Reset/idle: hold reset=0 for 2 cycles with in_val=2'b11 -> in_rdy=0, out_val=0, count=0; release -> ch0 granted first.
- Single request: ch1 type=3'd1, opaque=8'h5A, addr=32'h0000_1004, len=2'd0, domain=1 -> the next cycle out_val=1, out_msg={3'd1,8'h5A,32'h0000_1004,2'd0}, out_domain=1, out_port=1 (with OPQ_TAG_EN: opaque=8'h5B).
- Round-robin fairness: both channels valid continuously, out_rdy=1 -> grants alternate 0,1,0,1; out_port follows the same sequence one cycle later.
- Full/backpressure: out_rdy=0 with 5 requests offered (depth 4) -> count reaches 4, in_rdy=0, and out_msg stays on entry 0. With out_rdy=1 for one cycle -> count=3, and the next accept brings it back to 4.
- Simultaneous enq/deq at count=2 -> count stays 2, and order is preserved across pointer wrap after 10 transactions.
- Mid-stream reset with count=3 -> the next cycle count=0 and out_val=0; pre-reset entries never appear on the output.
